gate_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises a small combinational gate block (N_IN inputs, 1 output) in hardware. On start it walks every input vector 0..2^N_IN-1 onto the gate, waits a programmable settle time and captures each output into a truth-table register. It then compares the result against an expected table latched at start and reports pass/fail plus the first failing vector. It sits beside the gate under exercise as its self-check controller.

---
 rtl/gate_sweep_ctrl.sv | 114 +++++++++++
 tb/tb_gate_sweep_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive self-check sequencer for a small combinational gate: walks every
// input vector, captures the gate's truth table and compares it to an expected table.
module gate_sweep_ctrl #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [(1<<N_IN)-1:0]    expected,
  input  logic                    dut_out,
  output logic [N_IN-1:0]         dut_in,
  output logic                    busy,
  output logic                    done,
  output logic [(1<<N_IN)-1:0]    truth,
  output logic                    mismatch,
  output logic [N_IN-1:0]         first_err
);

  localparam int TW = 1 << N_IN;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
  localparam logic [7:0]      CNT_INIT = 8'(SETTLE);

  // Lowest set bit index of v; zero when v has no bits set.
  function automatic logic [N_IN-1:0] lowest_set(input logic [TW-1:0] v);
    logic [N_IN-1:0] idx;
    idx = '0;
    for (int k = TW - 1; k >= 0; k--) begin
      if (v[k]) idx = N_IN'(k);
    end
    return idx;
  endfunction

  logic [1:0]      state;
  logic [N_IN-1:0] vec;
  logic [7:0]      cnt;
  logic [TW-1:0]   exp_q;
  logic [TW-1:0]   truth_cap;

  // Table as it will look once the current sample lands, so the final
  // verdict includes the bit captured on the closing edge.
  always_comb begin
    truth_cap      = truth;
    truth_cap[vec] = dut_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vec       <= '0;
      cnt       <= '0;
      exp_q     <= '0;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      truth     <= '0;
      mismatch  <= 1'b0;
      first_err <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            exp_q     <= expected;
            truth     <= '0;
            mismatch  <= 1'b0;
            first_err <= '0;
            vec       <= '0;
            dut_in    <= '0;
            cnt       <= CNT_INIT;
            busy      <= 1'b1;
            state     <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (abort) begin
            busy   <= 1'b0;
            dut_in <= '0;
            state  <= ST_IDLE;
          end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            truth <= truth_cap;
            if (vec != VEC_LAST) begin
              vec    <= vec + 1'b1;
              dut_in <= vec + 1'b1;
              cnt    <= CNT_INIT;
            end else begin
              busy      <= 1'b0;
              done      <= 1'b1;
              dut_in    <= '0;
              mismatch  <= (truth_cap != exp_q);
              first_err <= lowest_set(truth_cap ^ exp_q);
              state     <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (SETTLE=1 and SETTLE=0) each driving
// a modelled gate; results are queued at start and checked when done appears.
module tb_gate_sweep_ctrl;

  typedef struct packed {
    logic [3:0] truth;
    logic       mismatch;
    logic [1:0] first_err;
  } result_t;

  logic       clk;
  logic       rst_n;
  logic       start1, start0;
  logic       abort;
  logic [3:0] expected;
  int         gate_sel;
  int         cur;

  logic [1:0] dut_in1, dut_in0;
  logic       dut_out1, dut_out0;
  logic       busy1, busy0, done1, done0, mm1, mm0;
  logic [3:0] truth1, truth0;
  logic [1:0] ferr1, ferr0;

  logic       s_busy, s_done, s_mm;
  logic [1:0] s_in, s_ferr;
  logic [3:0] s_truth;

  int n_cmp = 0;
  int n_err = 0;
  result_t sb[$];

  function automatic logic gate_fn(input int sel, input logic [1:0] v);
    case (sel)
      0:       return v[0] | v[1];
      1:       return v[0] & v[1];
      default: return v[0] ^ v[1];
    endcase
  endfunction

  function automatic result_t model(input int sel, input logic [3:0] e);
    result_t r;
    r.truth = '0;
    for (int k = 0; k < 4; k++) r.truth[k] = gate_fn(sel, 2'(k));
    r.mismatch  = (r.truth != e);
    r.first_err = '0;
    for (int k = 3; k >= 0; k--) if (r.truth[k] != e[k]) r.first_err = 2'(k);
    return r;
  endfunction

  assign dut_out1 = gate_fn(gate_sel, dut_in1);
  assign dut_out0 = gate_fn(gate_sel, dut_in0);

  assign s_busy  = (cur == 1) ? busy1  : busy0;
  assign s_done  = (cur == 1) ? done1  : done0;
  assign s_mm    = (cur == 1) ? mm1    : mm0;
  assign s_in    = (cur == 1) ? dut_in1 : dut_in0;
  assign s_ferr  = (cur == 1) ? ferr1  : ferr0;
  assign s_truth = (cur == 1) ? truth1 : truth0;

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .expected(expected),
    .dut_out(dut_out1), .dut_in(dut_in1), .busy(busy1), .done(done1),
    .truth(truth1), .mismatch(mm1), .first_err(ferr1)
  );

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .expected(expected),
    .dut_out(dut_out0), .dut_in(dut_in0), .busy(busy0), .done(done0),
    .truth(truth0), .mismatch(mm0), .first_err(ferr0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Full sweep on instance 'which'; optional mid-sweep start/expected disturbance
  // and optional abort asserted together with start.
  task automatic sweep(input int which, input int sel, input logic [3:0] exp_tab,
                       input bit disturb, input bit with_abort);
    int hold;
    logic [1:0] vq[$];
    logic [1:0] ein;
    result_t r;
    cur = which;
    hold = (which == 1) ? 2 : 1;
    gate_sel = sel;
    expected = exp_tab;
    sb.push_back(model(sel, exp_tab));
    for (int v = 0; v < 4; v++) for (int h = 0; h < hold; h++) vq.push_back(2'(v));
    if (which == 1) start1 = 1'b1; else start0 = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start1 = 1'b0; start0 = 1'b0; abort = 1'b0;
    for (int n = 1; n <= 4 * hold + 1; n++) begin
      if (n <= 4 * hold) begin
        ein = vq.pop_front();
        n_cmp++; if (s_busy !== 1'b1) begin n_err++; $display("FAIL sweep%0d busy n=%0d got=%b want=1", which, n, s_busy); end
        n_cmp++; if (s_in !== ein) begin n_err++; $display("FAIL sweep%0d dut_in n=%0d got=%0d want=%0d", which, n, s_in, ein); end
        n_cmp++; if (s_done !== 1'b0) begin n_err++; $display("FAIL sweep%0d early_done n=%0d got=%b want=0", which, n, s_done); end
      end else begin
        r = sb.pop_front();
        n_cmp++; if (s_done !== 1'b1) begin n_err++; $display("FAIL sweep%0d done n=%0d got=%b want=1", which, n, s_done); end
        n_cmp++; if (s_busy !== 1'b0) begin n_err++; $display("FAIL sweep%0d busy_end got=%b want=0", which, s_busy); end
        n_cmp++; if (s_in !== 2'd0) begin n_err++; $display("FAIL sweep%0d dut_in_end got=%0d want=0", which, s_in); end
        n_cmp++; if (s_truth !== r.truth) begin n_err++; $display("FAIL sweep%0d truth got=%b want=%b", which, s_truth, r.truth); end
        n_cmp++; if (s_mm !== r.mismatch) begin n_err++; $display("FAIL sweep%0d mismatch got=%b want=%b", which, s_mm, r.mismatch); end
        n_cmp++; if (s_ferr !== r.first_err) begin n_err++; $display("FAIL sweep%0d first_err got=%0d want=%0d", which, s_ferr, r.first_err); end
      end
      if (disturb && n == 3) begin
        if (which == 1) start1 = 1'b1; else start0 = 1'b1;
        expected = ~exp_tab;
      end else begin
        start1 = 1'b0; start0 = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++; if (s_done !== 1'b0) begin n_err++; $display("FAIL sweep%0d done_pulse_width got=%b want=0", which, s_done); end
    n_cmp++; if (s_busy !== 1'b0) begin n_err++; $display("FAIL sweep%0d no_restart busy got=%b want=0", which, s_busy); end
    expected = exp_tab;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start1 = 1'b0; start0 = 1'b0; abort = 1'b0;
    expected = 4'b0000; gate_sel = 0; cur = 1;
    #1;
    n_cmp++; if ({busy1, done1, truth1, mm1, ferr1, dut_in1} !== 11'd0) begin n_err++; $display("FAIL reset_s1 got=%b want=0", {busy1, done1, truth1, mm1, ferr1, dut_in1}); end
    n_cmp++; if ({busy0, done0, truth0, mm0, ferr0, dut_in0} !== 11'd0) begin n_err++; $display("FAIL reset_s0 got=%b want=0", {busy0, done0, truth0, mm0, ferr0, dut_in0}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_or_pass;        sweep(1, 0, 4'b1110, 1'b0, 1'b0); endtask
  task automatic test_and_mismatch;   sweep(1, 1, 4'b0110, 1'b0, 1'b0); endtask
  task automatic test_last_bit_err;   sweep(1, 0, 4'b0110, 1'b0, 1'b0); endtask
  task automatic test_restart_ignored; sweep(1, 2, 4'b0110, 1'b1, 1'b0); endtask
  task automatic test_start_abort;    sweep(1, 0, 4'b1110, 1'b0, 1'b1); endtask

  task automatic test_settle0;
    sweep(0, 2, 4'b0110, 1'b0, 1'b0);
    sweep(0, 0, 4'b0111, 1'b0, 1'b0);
  endtask

  // abort outside SWEEP must not disturb held results
  task automatic test_abort_idle;
    cur = 1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL abort_idle busy got=%b want=0", busy1); end
    n_cmp++; if (truth1 !== 4'b1000) begin n_err++; $display("FAIL abort_idle truth got=%b want=1000", truth1); end
    n_cmp++; if (mm1 !== 1'b1) begin n_err++; $display("FAIL abort_idle mismatch_held got=%b want=1", mm1); end
  endtask

  task automatic test_abort;
    result_t r;
    cur = 1; gate_sel = 0; expected = 4'b1110;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (dut_in1 !== 2'd2) begin n_err++; $display("FAIL abort pre dut_in got=%0d want=2", dut_in1); end
    abort = 1'b1;
    sb.push_back('{truth: 4'b0010, mismatch: 1'b0, first_err: 2'd0});
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL abort busy got=%b want=0", busy1); end
    n_cmp++; if (dut_in1 !== 2'd0) begin n_err++; $display("FAIL abort dut_in got=%0d want=0", dut_in1); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (done1 !== 1'b0) begin n_err++; $display("FAIL abort no_done cyc=%0d got=%b want=0", i, done1); end
      @(negedge clk);
    end
    r = sb.pop_front();
    n_cmp++; if (truth1 !== r.truth) begin n_err++; $display("FAIL abort truth got=%b want=%b", truth1, r.truth); end
    n_cmp++; if (mm1 !== r.mismatch) begin n_err++; $display("FAIL abort mismatch got=%b want=%b", mm1, r.mismatch); end
    n_cmp++; if (ferr1 !== r.first_err) begin n_err++; $display("FAIL abort first_err got=%0d want=%0d", ferr1, r.first_err); end
    sweep(1, 0, 4'b1110, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    cur = 1; gate_sel = 0; expected = 4'b1110;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (truth1 !== 4'b0010) begin n_err++; $display("FAIL rst_mid partial truth got=%b want=0010", truth1); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy1, done1, truth1, mm1, ferr1, dut_in1} !== 11'd0) begin n_err++; $display("FAIL rst_mid outputs got=%b want=0", {busy1, done1, truth1, mm1, ferr1, dut_in1}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if ({done1, busy1} !== 2'b00) begin n_err++; $display("FAIL rst_mid idle cyc=%0d got=%b want=00", i, {done1, busy1}); end
      @(negedge clk);
    end
    sweep(1, 1, 4'b1000, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_or_pass;
    test_and_mismatch;
    test_abort_idle;
    test_last_bit_err;
    test_settle0;
    test_abort;
    test_restart_ignored;
    test_start_abort;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
